// File: rtl/wisc_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encoding and drain depth.
package wisc_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_FILL_I = 3'd1,
    ST_FILL_D = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALT   = 3'd4
  } pcu_state_e;

  localparam int DRAIN_DEPTH = 3;
  localparam int DRAIN_W     = 2;

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_DEPTH);

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at 0xFFFF; synchronous active-low reset.
module sat_counter16 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush/fill sequencer with HLT drain. Optional stall counter: PIPE_CTRL_PERF_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | normal issue; handles misses, load-use, HLT, taken branch
// ST_FILL_I | I-cache line fill in flight, pipeline frozen
// ST_FILL_D | D-cache line fill in flight, pipeline frozen
// ST_DRAIN  | HLT seen; fetch stopped while older instructions retire
// ST_HALT   | processor halted, left only by reset
module pipe_ctrl_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use_hz,
  input  logic        br_taken,
  input  logic        dec_hlt,
  input  logic        icache_miss,
  input  logic        dcache_miss,
  input  logic        fill_done,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fill_start,
  output logic        fill_sel,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  import wisc_pkg::*;

  pcu_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 ret_drain_q, ret_drain_d;
  logic [DRAIN_W-1:0]   drain_dec;

  assign drain_dec = drain_q - DRAIN_W'(1);

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    ret_drain_d = ret_drain_q;
    {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    fill_start  = 1'b0;
    fill_sel    = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dcache_miss) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
          fill_start  = 1'b1;
          fill_sel    = 1'b1;
          ret_drain_d = 1'b0;
          state_d     = ST_FILL_D;
        end else if (icache_miss) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
          fill_start  = 1'b1;
          ret_drain_d = 1'b0;
          state_d     = ST_FILL_I;
        end else if (load_use_hz) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (dec_hlt) begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
          drain_d     = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else if (br_taken) begin
          if_id_flush = 1'b1;
        end
      end

      ST_FILL_I: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
        if (fill_done) begin
          if (dcache_miss) begin
            fill_start = 1'b1;
            fill_sel   = 1'b1;
            state_d    = ST_FILL_D;
          end else begin
            state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
          end
        end
      end

      ST_FILL_D: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
        fill_sel = 1'b1;
        // An I-miss while draining is stale fetch traffic, so never chain into it then.
        if (fill_done) begin
          if (icache_miss && !ret_drain_q) begin
            fill_start = 1'b1;
            fill_sel   = 1'b0;
            state_d    = ST_FILL_I;
          end else begin
            state_d = ret_drain_q ? ST_DRAIN : ST_RUN;
          end
        end
      end

      ST_DRAIN: begin
        if (dcache_miss) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
          fill_start  = 1'b1;
          fill_sel    = 1'b1;
          ret_drain_d = 1'b1;
          state_d     = ST_FILL_D;
        end else begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
          drain_d     = drain_dec;
          if (drain_q <= DRAIN_W'(1)) begin
            drain_d = '0;
            state_d = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
        halted = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset forces the pass-through pattern immediately, before the edge lands.
    if (!rst_n) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      fill_start  = 1'b0;
      fill_sel    = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      ret_drain_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ret_drain_q <= ret_drain_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  sat_counter16 u_stall_cnt (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .inc_i   (!pc_we && (state_q != ST_HALT)),
    .count_o (stall_cycles)
  );
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_use_hz = 1'b0;
  logic        br_taken = 1'b0;
  logic        dec_hlt = 1'b0;
  logic        icache_miss = 1'b0;
  logic        dcache_miss = 1'b0;
  logic        fill_done = 1'b0;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, fill_start, fill_sel, halted;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_use_hz  (load_use_hz),
    .br_taken     (br_taken),
    .dec_hlt      (dec_hlt),
    .icache_miss  (icache_miss),
    .dcache_miss  (dcache_miss),
    .fill_done    (fill_done),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .fill_start   (fill_start),
    .fill_sel     (fill_sel),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  // Behavioural model: what the processor is doing, not how the FSM encodes it.
  bit m_halted     = 1'b0;
  bit m_filling    = 1'b0;
  bit m_fill_d     = 1'b0;
  int m_drain_left = 0;
  int m_stalls     = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, fill_start, fill_sel, halted}
  function automatic logic [9:0] model_out();
    bit other;
    if (!rst_n)      return 10'b11111_00000;
    if (m_halted)    return 10'b00000_00001;
    if (m_filling) begin
      other = m_fill_d ? (icache_miss && (m_drain_left == 0)) : dcache_miss;
      if (fill_done && other) return {7'b0000000, 1'b1, !m_fill_d, 1'b0};
      return {7'b0000000, 1'b0, m_fill_d, 1'b0};
    end
    if (dcache_miss)        return 10'b00000_00110;
    if (m_drain_left > 0)   return 10'b01111_10000;
    if (icache_miss)        return 10'b00000_00100;
    if (load_use_hz)        return 10'b00111_01000;
    if (dec_hlt)            return 10'b01111_10000;
    if (br_taken)           return 10'b11111_10000;
    return 10'b11111_00000;
  endfunction

  always @(posedge clk) begin : mdl
    logic [9:0] o;
    o = model_out();
    if (!rst_n) begin
      m_halted = 0; m_filling = 0; m_fill_d = 0; m_drain_left = 0; m_stalls = 0;
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (!o[9] && !m_halted && m_stalls < 65535) m_stalls++;
`endif
      if (m_halted) begin
      end else if (m_filling) begin
        if (fill_done) begin
          if (o[2]) m_fill_d = !m_fill_d;
          else      m_filling = 0;
        end
      end else if (dcache_miss) begin
        m_filling = 1; m_fill_d = 1;
      end else if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end else if (icache_miss) begin
        m_filling = 1; m_fill_d = 0;
      end else if (load_use_hz) begin
      end else if (dec_hlt) begin
        m_drain_left = 3;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [9:0] exp_v, got_v;
    exp_v = model_out();
    got_v = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush, fill_start, fill_sel, halted};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got_v, exp_v);
    end
    checks++;
    if (stall_cycles !== 16'(m_stalls)) begin
      failures++;
      $display("FAIL stall_model t=%0t got=%0d exp=%0d", $time, stall_cycles, m_stalls);
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp_v);
    end
  endtask

  task automatic drv(input bit lu, input bit br, input bit hlt, input bit im, input bit dm, input bit fd);
    load_use_hz = lu; br_taken = br; dec_hlt = hlt;
    icache_miss = im; dcache_miss = dm; fill_done = fd;
  endtask

  task automatic drv_rand();
    drv(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 40) == 0,
        ($urandom % 10) == 0, ($urandom % 12) == 0, ($urandom % 3) == 0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [15:0] en5();
    return 16'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we});
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    neg();
    lit("rst_en", en5(), 16'h1F);
    lit("rst_halted", 16'(halted), 16'h0);
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    neg();
    lit("rst_en", en5(), 16'h1F);
    lit("rst_flush", 16'({if_id_flush, id_ex_flush, fill_start, fill_sel}), 16'h0);
    lit("rst_stall", stall_cycles, 16'h0);
    nxt(); nxt();
    rst_n = 1'b1;

    // load-use stall, branch ignored in the same cycle
    drv(1, 1, 0, 0, 0, 0); neg();
    lit("lu_pc", 16'(pc_we), 16'h0);
    lit("lu_ifid", 16'(if_id_we), 16'h0);
    lit("lu_idex_flush", 16'(id_ex_flush), 16'h1);
    lit("lu_br_ignored", 16'(if_id_flush), 16'h0);
    nxt();
    drv(0, 0, 0, 0, 0, 0); neg();
    lit("lu_after_en", en5(), 16'h1F);
    nxt();
    drv(0, 1, 0, 0, 0, 0); neg();
    lit("br_flush", 16'(if_id_flush), 16'h1);
    lit("br_en", en5(), 16'h1F);
    nxt();

    // both misses: D first, then chained I fill
    drv(0, 0, 0, 1, 1, 0); neg();
    lit("mm_fs", 16'(fill_start), 16'h1);
    lit("mm_sel", 16'(fill_sel), 16'h1);
    lit("mm_en", en5(), 16'h0);
    nxt();
    repeat (3) begin
      drv(0, 0, 0, 1, 1, 0); neg();
      lit("filld_en", en5(), 16'h0);
      lit("filld_fs", 16'(fill_start), 16'h0);
      lit("filld_sel", 16'(fill_sel), 16'h1);
      nxt();
    end
    drv(0, 0, 0, 1, 0, 1); neg();
    lit("chain_fs", 16'(fill_start), 16'h1);
    lit("chain_sel", 16'(fill_sel), 16'h0);
    nxt();
    repeat (3) begin
      drv(0, 0, 0, 1, 0, 0); neg();
      lit("filli_sel", 16'(fill_sel), 16'h0);
      lit("filli_en", en5(), 16'h0);
      nxt();
    end
    drv(0, 0, 0, 0, 0, 1); neg();
    lit("filli_done_fs", 16'(fill_start), 16'h0);
    nxt();
    drv(0, 0, 0, 0, 0, 0); neg();
    lit("back_run_en", en5(), 16'h1F);
    nxt();

    // HLT with a D-miss in the 2nd drain cycle
    drv(0, 0, 1, 0, 0, 0); neg();
    lit("hlt_pc", 16'(pc_we), 16'h0);
    lit("hlt_flush", 16'(if_id_flush), 16'h1);
    nxt();
    drv(0, 0, 0, 0, 0, 0); neg();
    lit("drain1_en", en5(), 16'h0F);
    nxt();
    drv(0, 0, 0, 0, 1, 0); neg();
    lit("drain_dm_fs", 16'(fill_start), 16'h1);
    lit("drain_dm_sel", 16'(fill_sel), 16'h1);
    lit("drain_dm_en", en5(), 16'h0);
    nxt();
    repeat (2) begin
      drv(0, 0, 0, 0, 1, 0); neg();
      lit("drain_fill_en", en5(), 16'h0);
      nxt();
    end
    drv(0, 0, 0, 1, 0, 1); neg();
    lit("drain_fd_no_ifill", 16'(fill_start), 16'h0);
    nxt();
    repeat (2) begin
      drv(0, 0, 0, 0, 0, 0); neg();
      lit("drain_resume_en", en5(), 16'h0F);
      lit("drain_resume_halt", 16'(halted), 16'h0);
      nxt();
    end
    drv(0, 0, 0, 0, 0, 0); neg();
    lit("halt_after_fill", 16'(halted), 16'h1);
    lit("halt_en", en5(), 16'h0);
    nxt();
    repeat (20) begin
      drv_rand(); neg();
      lit("halt_sticky", 16'(halted), 16'h1);
      nxt();
    end
    do_reset();

    // plain HLT: exactly three drain cycles
    drv(0, 0, 1, 0, 0, 0); nxt();
    repeat (3) begin
      drv(0, 1, 0, 1, 0, 0); neg();
      lit("drain3_en", en5(), 16'h0F);
      lit("drain3_halt", 16'(halted), 16'h0);
      nxt();
    end
    drv(0, 0, 0, 0, 0, 0); neg();
    lit("drain3_halted", 16'(halted), 16'h1);
    nxt();
    do_reset();

    // reset during a D fill, then a stray fill_done
    drv(0, 0, 0, 0, 1, 0); nxt();
    drv(0, 0, 0, 0, 1, 0); nxt();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 1, 1); neg();
    lit("rst_fill_fs", 16'(fill_start), 16'h0);
    lit("rst_fill_en", en5(), 16'h1F);
    nxt();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 1); neg();
    lit("stray_fd_fs", 16'(fill_start), 16'h0);
    lit("stray_fd_en", en5(), 16'h1F);
    nxt();

    // randomized traffic with occasional reset
    repeat (3000) begin
      drv_rand();
      rst_n = ($urandom % 150) != 0;
      nxt();
    end
    rst_n = 1'b1;

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    drv(0, 0, 0, 1, 0, 0);
    repeat (70000) nxt();
    neg();
    lit("stall_sat", stall_cycles, 16'hFFFF);
    nxt();
`else
    neg();
    lit("stall_tied", stall_cycles, 16'h0);
    nxt();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
